count_sched: RTL
================

# count_sched

Round-robin scheduler that shares one free-running up-counter (synchronous `clear`, increments every clock otherwise) among N requesters. Each requester asks for a timed interval of `limit+1` clock cycles. The scheduler grants the counter to one requester at a time and clears it at the start of the grant. It watches the count and pulses `done` to that requester when its terminal value is reached. It sits beside the counter instance and drives that counter's `clear` input.

## Interface

- `N`, 4: number of requesters, N ≥ 2.
- `W`, 4: counter width; must match the shared counter instance.
- `IW`, $clog2(N): width of `active_id`.

- `clock` in 1: single clock; all logic is on posedge.
- `clear` in 1: reset, synchronous and active-high.
- `req` in N: request level per requester.
- `limit` in N*W: terminal count per requester; slice i = `limit[i*W +: W]`.
- `ctr_count` in W: current value of the shared counter.
- `ctr_clear` out 1: drives the shared counter's `clear`.
- `grant` out N: one-hot, registered; requester currently owning the counter.
- `done` out N: one-cycle pulse, registered; interval of the granted requester complete.
- `busy` out 1: high in any state other than IDLE.
- `active_id` out IW: index of the current/last granted requester.

## Operation

- FSM states: IDLE, RUN, DONE.
- Outputs by state:
  - `ctr_clear` = 1 in IDLE and DONE, 0 in RUN (decoded combinationally from state).
  - `busy` = (state != IDLE).
- IDLE:
  - If `req` ≠ 0, pick a winner round-robin. The search starts at `last+1` mod N and wraps.
  - Register `grant` = one-hot(winner), `active_id` = winner, `lim` = limit slice, `last` = winner.
  - Go to RUN.
  - If `req` = 0, stay in IDLE.
- RUN:
  - If `ctr_count == lim`: set `done[active_id]` = 1 for the next cycle and go to DONE.
  - `req` is ignored in RUN, except as described under Configuration.
- DONE: lasts one cycle. `grant` is still held, `done` is high. Next state is IDLE with `grant` = 0 and `done` = 0. `req` is ignored in DONE.
- Latched `lim` is frozen for the whole grant; changes to `limit` during RUN have no effect.
- Width rule: comparison is W-bit equality.
  - `lim` = 0 gives a RUN of 1 cycle.
  - `lim` = 2^W−1 gives a RUN of 2^W cycles; the counter never wraps inside a grant.
- Reset values: `grant` = 0, `done` = 0, `busy` = 0, `ctr_clear` = 1, `active_id` = 0, state = IDLE, `last` = N−1 (requester 0 has first priority).
- `clear` has priority over every other event. Asserting it mid-RUN or in DONE returns to reset values on the next edge. No `done` is issued for the interrupted grant.

## Timing

- Request sampled in IDLE at cycle t:
  - `grant` high at t+1.
  - RUN occupies cycles t+1 … t+1+lim, with `ctr_count` = 0 … lim.
  - `done` pulses at t+2+lim.
  - `grant` drops at t+3+lim.
- Minimum spacing between successive grants is lim+3 cycles: RUN, then DONE, then one IDLE arbitration cycle.
- A requester holding `req` high continuously is re-granted only after every other active requester has been served.
- `done` and `grant` are registered. `ctr_clear`, `busy` and `active_id` are valid in the same cycle as state.

## Configuration

- Macro: `COUNT_SCHED_ABORT_EN`.
- Defined: in RUN, if `req[active_id]` = 0 and the count has not matched, go directly to IDLE on the next edge.
  - `grant` drops and no `done` is issued.
  - `last` is still updated, so round-robin order advances.
  - If the match and the request drop happen in the same cycle, the match wins: `done` is issued.
- Not defined: once granted, the interval always completes and `done` always pulses, regardless of `req`.

## Test plan

- Reset: `clear` = 1 for 2 cycles with `req` = 1111 → `grant` = 0, `done` = 0, `busy` = 0, `ctr_clear` = 1 throughout.
- Single request: `req` = 0001, limit0 = 3, sampled at t → `grant` = 0001 at t+1; `ctr_count` goes 0,1,2,3; `done` = 0001 only at t+5; `grant` = 0 and `busy` = 0 at t+6.
- Round robin: `req` = 1111 held, all limits = 0 → grants 0001, 0010, 0100, 1000, 0001 every 3 cycles, each followed by the matching `done` one cycle later.
- Max limit: limit2 = 15, `req` = 0100 → RUN lasts 16 cycles; `done` = 0100 at t+17; `ctr_count` never exceeds 15 during `grant`.
- Clear mid-run: limit1 = 9 and `clear` pulsed when `ctr_count` = 5 → next cycle `grant` = 0, `busy` = 0, no `done`. With `req` = 1111 afterwards, the first grant is 0001.
- Abort: `req` = 0001, limit0 = 8, `req` dropped at count 4.
  - With `COUNT_SCHED_ABORT_EN`: `grant` = 0 next cycle and no `done`.
  - Without it: `done` = 0001 at count 8 + 1 cycle.

Source files
------------

// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin scheduler that lends one shared free-running counter to N requesters
// Optional COUNT_SCHED_ABORT_EN: a request dropped during RUN abandons the grant without a done pulse.
module count_sched #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] limit,
  input  logic [W-1:0]   ctr_count,
  output logic           ctr_clear,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [IW-1:0]  active_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [N-1:0]  grant_n, done_n;
  logic [IW-1:0] active_id_n, last, last_n, winner;
  logic [W-1:0]  lim, lim_n;
  logic          found;
  int            idx;

  // Search starts just after the last winner and wraps, so a held request waits its turn.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    done_n      = '0;
    active_id_n = active_id;
    lim_n       = lim;
    last_n      = last;
    case (state)
      IDLE: begin
        if (found) begin
          state_n     = RUN;
          grant_n     = N'(1) << winner;
          active_id_n = winner;
          lim_n       = limit[winner*W +: W];
          last_n      = winner;
        end
      end
      RUN: begin
        if (ctr_count == lim) begin
          state_n = DONE;
          done_n  = N'(1) << active_id;
        end
`ifdef COUNT_SCHED_ABORT_EN
        else if (!req[active_id]) begin
          state_n = IDLE;
          grant_n = '0;
        end
`endif
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      active_id <= '0;
      lim       <= '0;
      last      <= IW'(N - 1);
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      done      <= done_n;
      active_id <= active_id_n;
      lim       <= lim_n;
      last      <= last_n;
    end
  end

  assign ctr_clear = (state != RUN);
  assign busy      = (state != IDLE);

endmodule
